// File: rtl/car_parking.sv
// car_parking: two-sensor gate that counts cars in and out of a lot.
// Sensors are synchronized, debounced, and decoded by a small FSM that only
// credits a full A-then-B (entry) or B-then-A (exit) pass. The count saturates at 0..7.
module car_parking #(
    parameter int DEBOUNCE_CYCLES = 500_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       a_btn,
    input  logic       b_btn,
    output logic [2:0] led_counter
);

    localparam int            CW      = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] EN1  = 3'd1;
    localparam logic [2:0] EN2  = 3'd2;
    localparam logic [2:0] EN3  = 3'd3;
    localparam logic [2:0] EX1  = 3'd4;
    localparam logic [2:0] EX2  = 3'd5;
    localparam logic [2:0] EX3  = 3'd6;
    localparam logic [2:0] ERR  = 3'd7;

    logic [1:0]    rst_sync_q;
    logic          rst_n;
    logic [1:0]    meta_q, sync_q;       // bit 0 = A, bit 1 = B
    logic [1:0]    deb_q, deb_d;
    logic [CW-1:0] dcnt_q [2];
    logic [CW-1:0] dcnt_d [2];
    logic [1:0]    flags;                // {sa, sb}, active-high "blocked"
    logic [2:0]    state_q, state_d;
    logic [2:0]    count_q, count_d;
    logic          inc, dec;

    // Reset assert passes straight through; release is retimed to clk.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rst_sync_q <= 2'b00;
        else        rst_sync_q <= {rst_sync_q[0], 1'b1};
    end

    assign rst_n = rst_sync_q[1];

    // Two-flop synchronizer for both sensors; idle level is 1 (clear).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 2'b11;
            sync_q <= 2'b11;
        end else begin
            meta_q <= {b_btn, a_btn};
            sync_q <= meta_q;
        end
    end

    // Debounce: the level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            deb_d[i]  = deb_q[i];
            dcnt_d[i] = '0;
            if (sync_q[i] != deb_q[i]) begin
                if (dcnt_q[i] == DB_LAST) deb_d[i]  = sync_q[i];
                else                      dcnt_d[i] = dcnt_q[i] + 1'b1;
            end
        end
    end

    // Debounce state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb_q     <= 2'b11;
            dcnt_q[0] <= '0;
            dcnt_q[1] <= '0;
        end else begin
            deb_q     <= deb_d;
            dcnt_q[0] <= dcnt_d[0];
            dcnt_q[1] <= dcnt_d[1];
        end
    end

    assign flags = {~deb_q[0], ~deb_q[1]};

    // Pass decoder: entry walks 10->11->01->00, exit walks 01->11->10->00.
    always_comb begin
        state_d = state_q;
        inc     = 1'b0;
        dec     = 1'b0;
        case (state_q)
            IDLE: case (flags)
                2'b10:   state_d = EN1;
                2'b01:   state_d = EX1;
                2'b11:   state_d = ERR;
                default: state_d = IDLE;
            endcase
            EN1: case (flags)
                2'b11:   state_d = EN2;
                2'b00:   state_d = IDLE;
                2'b01:   state_d = ERR;
                default: state_d = EN1;
            endcase
            EN2: case (flags)
                2'b01:   state_d = EN3;
                2'b10:   state_d = EN1;
                2'b00:   state_d = IDLE;
                default: state_d = EN2;
            endcase
            EN3: case (flags)
                2'b00:   begin state_d = IDLE; inc = 1'b1; end
                2'b11:   state_d = EN2;
                2'b10:   state_d = ERR;
                default: state_d = EN3;
            endcase
            EX1: case (flags)
                2'b11:   state_d = EX2;
                2'b00:   state_d = IDLE;
                2'b10:   state_d = ERR;
                default: state_d = EX1;
            endcase
            EX2: case (flags)
                2'b10:   state_d = EX3;
                2'b01:   state_d = EX1;
                2'b00:   state_d = IDLE;
                default: state_d = EX2;
            endcase
            EX3: case (flags)
                2'b00:   begin state_d = IDLE; dec = 1'b1; end
                2'b11:   state_d = EX2;
                2'b01:   state_d = ERR;
                default: state_d = EX3;
            endcase
            default: state_d = (flags == 2'b00) ? IDLE : ERR;
        endcase
    end

    // Saturating car count, updated on the completing transition.
    always_comb begin
        count_d = count_q;
        if (inc && count_q != 3'd7) count_d = count_q + 3'd1;
        if (dec && count_q != 3'd0) count_d = count_q - 3'd1;
    end

    // FSM and count registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            count_q <= 3'd0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    assign led_counter = count_q;

endmodule

// File: tb/tb_car_parking.sv
// tb_car_parking: directed and randomized sensor sequences checked against a
// path-position model of the lot gate.
module tb_car_parking;

    localparam int DB = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       a_btn, b_btn;
    logic [2:0] led_counter;

    int errors = 0;
    int checks = 0;

    // Model: position along the entry path (+1..+3) or exit path (-1..-3), 0 = idle.
    int m_cnt = 0;
    int m_pos = 0;
    bit m_err = 0;

    car_parking #(.DEBOUNCE_CYCLES(DB)) dut (
        .clk        (clk),
        .reset      (reset),
        .a_btn      (a_btn),
        .b_btn      (b_btn),
        .led_counter(led_counter)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance the model by one settled sensor pattern (a,b are raw active-low pins).
    function automatic void model_step(input bit a, input bit b);
        bit [1:0] p;
        bit [1:0] path [4];
        int m, s;
        p = {~a, ~b};
        if (m_err) begin
            if (p == 2'b00) m_err = 0;
            return;
        end
        if (p == 2'b00) begin
            if (m_pos == 3  && m_cnt < 7) m_cnt++;
            if (m_pos == -3 && m_cnt > 0) m_cnt--;
            m_pos = 0;
            return;
        end
        if (m_pos == 0) begin
            if (p == 2'b10)      m_pos = 1;
            else if (p == 2'b01) m_pos = -1;
            else                 m_err = 1;
            return;
        end
        s = (m_pos > 0) ? 1 : -1;
        m = m_pos * s;
        if (s > 0) begin path[1] = 2'b10; path[2] = 2'b11; path[3] = 2'b01; end
        else       begin path[1] = 2'b01; path[2] = 2'b11; path[3] = 2'b10; end
        path[0] = 2'b00;
        if (p == path[m]) return;
        if (m < 3 && p == path[m+1])      m_pos += s;
        else if (m > 1 && p == path[m-1]) m_pos -= s;
        else begin m_err = 1; m_pos = 0; end
    endfunction

    task automatic drive(input bit a, input bit b, input int n);
        @(negedge clk);
        a_btn = a;
        b_btn = b;
        repeat (n) @(negedge clk);
        model_step(a, b);
    endtask

    // Apply n patterns packed left-to-right as {a,b} pairs, then check the count.
    task automatic seq(input string tag, input bit [9:0] p, input int n);
        for (int i = 0; i < n; i++)
            drive(p[2*(n-1-i)+1], p[2*(n-1-i)], 20);
        chk(tag, led_counter, 8'(m_cnt));
    endtask

    task automatic glitch_a(input int len);
        bit keep;
        keep = a_btn;
        @(negedge clk);
        a_btn = ~keep;
        repeat (len) @(negedge clk);
        a_btn = keep;
        repeat (12) @(negedge clk);
    endtask

    localparam bit [9:0] ENTRY = 10'b11_01_00_10_11;
    localparam bit [9:0] EXIT  = 10'b11_10_00_01_11;

    initial begin
        int mode, hold;
        bit ra, rb;

        reset = 1'b0;
        a_btn = 1'b1;
        b_btn = 1'b1;
        repeat (5) @(negedge clk);
        chk("reset_led", led_counter, 8'd0);
        reset = 1'b1;
        repeat (5) @(negedge clk);

        // Basic entry and exit
        seq("entry", ENTRY, 5);
        chk("entry_one", led_counter, 8'd1);
        seq("exit", EXIT, 5);
        chk("exit_zero", led_counter, 8'd0);

        // Aborted and anomalous passes leave the count alone
        seq("ped_a",     10'b00_00_00_01_11, 2);
        seq("ped_b",     10'b00_00_00_10_11, 2);
        seq("abort_in",  10'b00_01_00_01_11, 4);
        seq("abort_out", 10'b00_10_00_10_11, 4);
        seq("anomaly",   10'b00_00_11_00_11, 3);
        chk("aborts_zero", led_counter, 8'd0);

        // Saturation at both ends
        for (int i = 0; i < 8; i++) begin
            seq("fill", ENTRY, 5);
            chk("fill_const", led_counter, 8'((i < 7) ? i + 1 : 7));
        end
        for (int i = 0; i < 8; i++) seq("drain", EXIT, 5);
        chk("drain_zero", led_counter, 8'd0);

        // Short glitches: idle, and mid-entry where an accepted glitch would abort the pass
        seq("pre_glitch", ENTRY, 5);
        seq("pre_glitch2", ENTRY, 5);
        glitch_a(3);
        chk("glitch_idle", led_counter, 8'(m_cnt));
        drive(1'b0, 1'b1, 20);
        glitch_a(2);
        drive(1'b0, 1'b0, 20);
        drive(1'b1, 1'b0, 20);
        drive(1'b1, 1'b1, 20);
        chk("glitch_entry", led_counter, 8'd3);

        // Async reset while parked in the middle of an entry
        drive(1'b0, 1'b1, 20);
        drive(1'b0, 1'b0, 20);
        #2;
        reset = 1'b0;
        #1;
        chk("async_rst", led_counter, 8'd0);
        chk("rst_state_idle", 8'(dut.state_q), 8'd0);
        a_btn = 1'b1;
        b_btn = 1'b1;
        m_cnt = 0; m_pos = 0; m_err = 0;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        repeat (20) @(negedge clk);
        chk("post_rst_state", 8'(dut.state_q), 8'd0);
        drive(1'b1, 1'b0, 20);
        drive(1'b1, 1'b1, 20);
        chk("post_rst_tail", led_counter, 8'd0);
        seq("post_rst_entry", ENTRY, 5);
        chk("post_rst_one", led_counter, 8'd1);

        // Randomized traffic: loose patterns, whole passes, and glitches
        for (int it = 0; it < 120; it++) begin
            mode = $urandom_range(0, 3);
            if (mode == 1) seq("rnd_entry", ENTRY, 5);
            else if (mode == 2) seq("rnd_exit", EXIT, 5);
            else begin
                ra = 1'($urandom);
                rb = 1'($urandom);
                hold = 20 + $urandom_range(0, 10);
                drive(ra, rb, hold);
                chk("rnd_pat", led_counter, 8'(m_cnt));
                if ($urandom_range(0, 3) == 0) begin
                    glitch_a($urandom_range(1, DB - 1));
                    chk("rnd_glitch", led_counter, 8'(m_cnt));
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/car_parking.md
CAR_PARKING -- requirements
Module: car_parking

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 500_000: consecutive stable clock cycles required before a debounced sensor level changes.
REQ-002 SHALL have port clk, input, 1 bit: single system clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-low reset (0 = in reset).
REQ-004 SHALL have port a_btn, input, 1 bit: outer sensor A, active-low (0 = blocked, 1 = clear).
REQ-005 SHALL have port b_btn, input, 1 bit: inner sensor B, active-low (0 = blocked, 1 = clear).
REQ-006 SHALL have port led_counter, output, 3 bits: current car count, unsigned, active-high.

Function
REQ-007 SHALL pass each of a_btn and b_btn through a 2-flip-flop synchronizer before use.
REQ-008 SHALL debounce each synchronized input independently.
- Debounced level changes only after the synchronized level has differed from it for DEBOUNCE_CYCLES consecutive cycles.
- Any return to the current debounced level restarts the count.
REQ-009 SHALL derive internal active-high flags sa = NOT debounced A and sb = NOT debounced B.
REQ-010 SHALL implement an FSM with states IDLE, EN1, EN2, EN3, EX1, EX2, EX3 and ERR, evaluated every cycle on (sa,sb).
REQ-011 From IDLE, the FSM SHALL go:
- (1,0) -> EN1
- (0,1) -> EX1
- (1,1) -> ERR
- (0,0) -> stay in IDLE
REQ-012 From EN1, the FSM SHALL go:
- (1,1) -> EN2
- (0,0) -> IDLE, no count change (pedestrian aborted)
- (0,1) -> ERR
- (1,0) -> stay
REQ-013 From EN2, the FSM SHALL go:
- (0,1) -> EN3
- (1,0) -> EN1 (car backs out)
- (0,0) -> IDLE, no count change
- (1,1) -> stay
REQ-014 From EN3, the FSM SHALL go:
- (0,0) -> IDLE and increment the count
- (1,1) -> EN2
- (1,0) -> ERR
- (0,1) -> stay
REQ-015 EX1/EX2/EX3 SHALL mirror EN1/EN2/EN3 with the roles of sa and sb swapped; EX3 -> IDLE on (0,0) SHALL decrement the count.
REQ-016 From ERR, the FSM SHALL go to IDLE only on (0,0), with no count change; all other inputs hold ERR.
REQ-017 The counter SHALL update on the same clock edge as the EN3->IDLE or EX3->IDLE transition; led_counter SHALL reflect it one cycle after the debounced flags read (0,0).
REQ-018 The counter SHALL saturate:
- increment at 7 holds 7
- decrement at 0 holds 0
- no wrap-around in either direction
REQ-019 The count SHALL change by at most 1 per complete pass; holding any state indefinitely SHALL NOT change the count.
REQ-020 led_counter SHALL be driven directly from the count register, with no combinational path from a_btn or b_btn.

Reset
REQ-021 While reset = 0, the block SHALL asynchronously force:
- FSM to IDLE
- count to 0 and led_counter to 3'b000
- synchronizer and debounced levels to 1 (clear)
- debounce counters to 0
REQ-022 Reset SHALL be released synchronously into the flops (reset-deassert synchronizer).
REQ-023 A reset asserted mid-sequence SHALL discard the partial sequence; after release, the block SHALL need a full new sequence starting from IDLE to count.

Verification (benches SHALL use DEBOUNCE_CYCLES = 4, holding each input pattern for at least 20 cycles)
REQ-024 Reset, then entry (a,b) = 11 -> 01 -> 00 -> 10 -> 11 -> led_counter = 1; then exit 11 -> 10 -> 00 -> 01 -> 11 -> led_counter = 0.
REQ-025 From count 0, these sequences SHALL each leave led_counter = 0:
- pedestrian aborts: 01 -> 11, and 10 -> 11
- car aborts mid-entry: 01 -> 00 -> 01 -> 11
- car aborts mid-exit: 10 -> 00 -> 10 -> 11
- anomaly: 11 -> 00 -> 11
REQ-026 Eight valid entries from count 0 SHALL give led_counter 1,2,...,7,7; an exit at 0 SHALL leave led_counter = 0.
REQ-027 A glitch on a_btn shorter than DEBOUNCE_CYCLES SHALL cause no FSM transition and no count change.
REQ-028 Drive reset = 0 while in EN2 with count = 3 -> led_counter = 0 immediately (asynchronous); after release with inputs 11, the FSM SHALL be in IDLE.
